// File: rtl/systolic_array_pkg.sv
// Shared types for the systolic array datapath and its sequencer.
// Latency: none (types, constants and a helper function only).
// Backpressure: not applicable.
package systolic_array_pkg;

    localparam int WORD_W = 16;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [2:0] {
        SA_IDLE  = 3'd0,
        SA_START = 3'd1,
        SA_FEED  = 3'd2,
        SA_DRAIN = 3'd3,
        SA_READ  = 3'd4,
        SA_DONE  = 3'd5
    } sa_ctrl_state_t;

    // Non-stalled drain cycles: N-1 to flush the skew line plus 2N-1 for
    // the wavefront to cross the array.
    function automatic int sa_drain_cycles(input int n);
        return 3 * n - 2;
    endfunction

endpackage

// File: rtl/systolic_array_ctrl_operand_skew.sv
// Triangular shift register that staggers operand lanes for the array.
// Latency: lane i appears i+1 pushes after entry (DELAY_DIR=0), else N-i.
// Backpressure: advances only on push; holds otherwise; clear zeroes all.
module operand_skew
    import systolic_array_pkg::*;
#(
    parameter int N         = 4,
    parameter int DELAY_DIR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              clear,
    input  word_t [N-1:0]     din,
    output word_t [N-1:0]     dout
);

    for (genvar i = 0; i < N; i++) begin : g_lane
        // Lane 0 is a single register, so its output is the registered head.
        localparam int DEPTH = (DELAY_DIR == 0) ? (i + 1) : (N - i);

        word_t stage [DEPTH];

        // Shift one slot per push; a vacated head is refilled by din (zero in drain).
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int k = 0; k < DEPTH; k++) stage[k] <= '0;
            end else if (clear) begin
                for (int k = 0; k < DEPTH; k++) stage[k] <= '0;
            end else if (push) begin
                stage[0] <= din[i];
                for (int k = 1; k < DEPTH; k++) stage[k] <= stage[k-1];
            end
        end

        assign dout[i] = stage[DEPTH-1];
    end

endmodule

// File: rtl/systolic_array_ctrl.sv
// Sequencer: takes a K-vector matmul command, feeds skewed operands, drains, returns N rows.
// Latency: with no stalls, done pulses K+4N cycles after the command is accepted.
// Backpressure: sa_stall freezes FEED/DRAIN; res_ready holds the current row in READ.
module systolic_array_ctrl
    import systolic_array_pkg::*;
#(
    parameter int N     = 4,
    parameter int LEN_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [LEN_W-1:0]      cmd_len,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  word_t [N-1:0]         op_x,
    input  word_t [N-1:0]         op_w,
    output logic                  sa_start,
    output word_t [N-1:0]         sa_x,
    output word_t [N-1:0]         sa_w,
    output logic [$clog2(N)-1:0]  sa_y_index,
    input  word_t [N-1:0]         sa_y,
    input  logic                  sa_stall,
    output logic                  res_valid,
    input  logic                  res_ready,
    output word_t [N-1:0]         res_data,
    output logic [$clog2(N)-1:0]  res_row,
    output logic                  res_last,
    output logic                  busy,
    output logic                  done
);

    localparam int IDX_W      = $clog2(N);
    localparam int DRN_W      = $clog2(3 * N);
    localparam int DRAIN_LAST = sa_drain_cycles(N) - 1;

    localparam logic [2:0] S_IDLE  = SA_IDLE;
    localparam logic [2:0] S_START = SA_START;
    localparam logic [2:0] S_FEED  = SA_FEED;
    localparam logic [2:0] S_DRAIN = SA_DRAIN;
    localparam logic [2:0] S_READ  = SA_READ;
    localparam logic [2:0] S_DONE  = SA_DONE;

    logic [2:0]       state;
    logic [LEN_W-1:0] k_len;
    logic [LEN_W-1:0] accept_cnt;
    logic [DRN_W-1:0] drain_cnt;
    logic [IDX_W-1:0] row_cnt;

    logic          cmd_fire;
    logic          op_fire;
    logic          drain_step;
    logic          res_fire;
    logic          skew_push;
    word_t [N-1:0] skew_x_in;
    word_t [N-1:0] skew_w_in;

    assign cmd_ready  = (state == S_IDLE);
    assign cmd_fire   = cmd_valid && cmd_ready;
    assign op_ready   = (state == S_FEED) && !sa_stall;
    assign op_fire    = op_valid && op_ready;
    assign drain_step = (state == S_DRAIN) && !sa_stall;
    assign res_valid  = (state == S_READ);
    assign res_fire   = res_valid && res_ready;
    assign res_last   = res_valid && (row_cnt == IDX_W'(N - 1));
    assign res_data   = sa_y;
    assign res_row    = row_cnt;
    assign sa_y_index = row_cnt;
    assign sa_start   = (state == S_START);
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);

    // Drain cycles push zero vectors so the last operands walk out of the skew line.
    assign skew_push  = op_fire || drain_step;
    assign skew_x_in  = op_fire ? op_x : '0;
    assign skew_w_in  = op_fire ? op_w : '0;

    operand_skew #(.N(N), .DELAY_DIR(0)) u_skew_x (
        .clk   (clk),
        .rst   (rst),
        .push  (skew_push),
        .clear (cmd_fire),
        .din   (skew_x_in),
        .dout  (sa_x)
    );

    operand_skew #(.N(N), .DELAY_DIR(0)) u_skew_w (
        .clk   (clk),
        .rst   (rst),
        .push  (skew_push),
        .clear (cmd_fire),
        .din   (skew_w_in),
        .dout  (sa_w)
    );

    // Job sequencing: state plus the accept, drain and row counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            k_len      <= '0;
            accept_cnt <= '0;
            drain_cnt  <= '0;
            row_cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_fire) begin
                        k_len      <= cmd_len;
                        accept_cnt <= '0;
                        drain_cnt  <= '0;
                        row_cnt    <= '0;
                        state      <= (cmd_len == '0) ? S_DONE : S_START;
                    end
                end
                S_START: state <= S_FEED;
                S_FEED: begin
                    if (op_fire) begin
                        accept_cnt <= accept_cnt + LEN_W'(1);
                        if (accept_cnt == k_len - LEN_W'(1)) state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (drain_step) begin
                        if (drain_cnt == DRN_W'(DRAIN_LAST)) state <= S_READ;
                        else drain_cnt <= drain_cnt + DRN_W'(1);
                    end
                end
                S_READ: begin
                    if (res_fire) begin
                        if (row_cnt == IDX_W'(N - 1)) begin
                            row_cnt <= '0;
                            state   <= S_DONE;
                        end else begin
                            row_cnt <= row_cnt + IDX_W'(1);
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/systolic_array_ctrl.md
# systolic_array_ctrl

Sequencer for the N×N `systolic_array` datapath. It accepts a matrix-multiply command and streams K operand vectors into the array with the diagonal skew the array needs. It then drains the pipeline and returns the N result rows over a valid/ready port. It sits between the operand buffers/DMA and the array, and it alone drives `start`, `x_in`, `w_in` and `y_index`.

## Interface
- `N`, default 4: array dimension; must match the attached array.
- `LEN_W`, default 8: width of the K (operand-vector count) field.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `cmd_valid` in 1; `cmd_ready` out 1; `cmd_len` in LEN_W: K, the number of operand vectors for this job.
- `op_valid` in 1; `op_ready` out 1; `op_x` in N×word_t (x column for one step); `op_w` in N×word_t (w row for one step).
- `sa_start` out 1: drives the array `start` input.
- `sa_x`, `sa_w` out N×word_t: skewed operands to the array `x_in`/`w_in`.
- `sa_y_index` out $clog2(N): row select to the array.
- `sa_y` in N×word_t; `sa_stall` in 1: from array `y_out`/`stall`.
- `res_valid` out 1; `res_ready` in 1; `res_data` out N×word_t; `res_row` out $clog2(N); `res_last` out 1.
- `busy` out 1: state ≠ IDLE. `done` out 1: one-cycle completion pulse.

## Operation
- States: IDLE, START, FEED, DRAIN, READ, DONE.
- **IDLE**
  - `cmd_ready`=1.
  - On a `cmd_valid && cmd_ready` handshake, latch K=`cmd_len`.
  - If K=0, go to DONE (no result rows); otherwise go to START.
- **START**
  - One cycle with `sa_start`=1. `sa_x`/`sa_w` are driven from the zeroed skew line.
  - Next state is FEED.
- **FEED**
  - `op_ready` = !`sa_stall`.
  - Each op handshake pushes `op_x`/`op_w` into the skew line and increments the accepted count.
  - After the K-th handshake, go to DRAIN.
  - A cycle with no handshake (`op_valid`=0 or stalled) does not advance the skew line.
- **Skew line**
  - Lane i of x (row i) is delayed i pushes; lane j of w (column j) is delayed j pushes.
  - Lane 0 is combinational pass-through of the registered head.
  - Vacated slots fill with zero.
  - `sa_x[i]` and `sa_w[j]` are the lane tails.
- **DRAIN**
  - Each cycle with `sa_stall`=0 pushes a zero vector and increments the drain counter. `sa_stall`=1 freezes both the counter and the skew line.
  - After 3N-2 non-stalled cycles (N-1 skew flush plus 2N-1 array propagation), go to READ.
- **READ**
  - `sa_y_index`=row counter r (starts at 0); `res_data`=`sa_y`; `res_row`=r; `res_valid`=1; `res_last` = (r==N-1).
  - Each `res_valid && res_ready` handshake increments r.
  - The handshake with r=N-1 moves the FSM to DONE.
  - `res_data` is held stable while `res_ready`=0.
- **DONE**
  - One cycle with `done`=1 and `cmd_ready`=0, then IDLE.
- Arithmetic is none: operands are passed through unmodified. All counters are sized to LEN_W or $clog2(3N) and never wrap inside a job.
- While not IDLE, `cmd_ready`=0; a command presented then is held off, not dropped.

## Timing
- Reset (asynchronous, asserted `rst`=1):
  - FSM goes to IDLE; skew line, counters, `sa_start`, `op_ready`, `res_valid`, `res_last`, `done`, `busy`, `sa_y_index`, `res_row` = 0; `sa_x`/`sa_w` = 0.
  - `cmd_ready`=1 from the first cycle after release.
- Reset mid-job aborts the job with no `done` and no further result rows.
- With the command accepted at cycle 0 and no stalls or bubbles:
  - `sa_start` at cycle 1.
  - Ops accepted at cycles 2..K+1.
  - DRAIN runs cycles K+2..K+3N-1.
  - `res_valid` first at cycle K+3N.
  - With `res_ready`=1 throughout, rows at K+3N..K+4N-1 and `done` at K+4N.
- Every stall cycle in FEED or DRAIN adds exactly one cycle. `sa_stall` is ignored in IDLE, START, READ and DONE.
- All outputs are registered or decoded from state/registers only, except `op_ready` (depends on `sa_stall`) and `res_data` (= `sa_y`).

## Structure
- In `systolic_array_pkg`:
  - reuse `word_t`;
  - add a `sa_ctrl_state_t` enum for the six states;
  - add function `sa_drain_cycles(N)` = 3N-2.
- One sub-module: `operand_skew` (parameters N, DELAY_DIR), instantiated twice (x lanes, w lanes). It is a triangular shift register with inputs `push`, `din[N]`, `clear` and output `dout[N]`.
- The FSM and counters live in `systolic_array_ctrl`.

## Test plan
- **Basic job:** N=4, K=4, identity x, w rows 1..4, `res_ready`=1, no stalls → `sa_start` at cycle 1, `res_valid` at cycle 16, rows 0..3 = w, `res_last` on row 3, `done` at cycle 20.
- **Skew check:** push op_x=[1,2,3,4] once, then zeros → `sa_x[0]`=1 on push 1; `sa_x[3]`=4 appears only on push 4; all other slots are 0.
- **Stalls:** `sa_stall`=1 for 3 cycles mid-FEED and 2 cycles mid-DRAIN → `op_ready`=0 and `sa_x`/`sa_w` frozen during the stall; `done` lands exactly 5 cycles later than in the no-stall run.
- **Backpressure:** `res_ready` toggles 0,1,0,1,… in READ → each row is emitted once in order 0..3 and `res_data` stays stable while held; a `cmd_valid` asserted during READ is not accepted until the cycle after `done`.
- **Zero-length:** `cmd_len`=0 → no `sa_start`, no `res_valid`, `done` 1 cycle after acceptance.
- **Reset mid-DRAIN:** assert `rst` → all outputs are 0 within the same cycle; `cmd_ready`=1 after release; the next job (K=2) produces correct results.
